// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the round-level datapath blocks.
// Byte k of a 128-bit state is state[127-8k -: 8]: byte 0 is the MSB byte,
// which matches the column-major AES state layout.
package aes_pkg;

  localparam int NBYTES = 16;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  // SubBytes sequencer FSM states.
  typedef enum logic [1:0] {
    SUB_IDLE  = 2'd0,
    SUB_ISSUE = 2'd1,
    SUB_DRAIN = 2'd2,
    SUB_DONE  = 2'd3
  } sub_seq_state_e;

  // Extract byte idx (0 = MSB byte) from a state.
  function automatic byte_t get_byte(input state_t s, input int idx);
    int lo;
    lo = 8 * (NBYTES - 1 - idx);
    return s[lo +: 8];
  endfunction

  // Return s with byte idx (0 = MSB byte) replaced by b.
  function automatic state_t put_byte(input state_t s, input int idx, input byte_t b);
    state_t r;
    int     lo;
    r = s;
    lo = 8 * (NBYTES - 1 - idx);
    r[lo +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/sub_bytes_seq.sv
// SubBytes sequencer: streams the 16 bytes of a captured AES state through an
// external synchronous S-Box stage one per cycle and reassembles the result.
//
// Handshake: start is a request that is honoured only in IDLE or DONE; the
// accepting edge is E0. busy is high from E0 until the completion edge.
// done is a one-cycle pulse coinciding with the first cycle state_out holds
// the new result; state_out is then held until the next accepted start.
//
// Timing: byte k is loaded into sbox_addr at edge Ek and tagged with its
// index. The tag walks a SBOX_LATENCY-deep pipe, so sbox_data for byte k is
// written into the assembly register at edge E(k+SBOX_LATENCY+1). The last
// byte lands at E(16+SBOX_LATENCY), which is also when state_out and done
// update.
module sub_bytes_seq #(
  parameter int SBOX_LATENCY = 1,
  parameter int NBYTES       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data
);

  import aes_pkg::*;

  localparam int IDX_W = $clog2(NBYTES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // FSM
  sub_seq_state_e r_state;
  sub_seq_state_e w_state_nxt;

  // Datapath registers
  state_t           r_data;       // captured input state
  state_t           r_assy;       // result under assembly
  state_t           r_out;        // published result
  logic             r_done;
  byte_t            r_sbox_addr;
  logic [CNT_W-1:0] r_issue_cnt;  // next byte index to issue
  logic             r_iss_vld;    // sbox_addr carries a tagged byte this cycle
  logic [IDX_W-1:0] r_iss_idx;

  // Tag pipe, aligned with the S-Box latency
  logic [SBOX_LATENCY-1:0] r_pipe_vld;
  logic [IDX_W-1:0]        r_pipe_idx [SBOX_LATENCY];

  // Control decodes
  logic             w_accept;
  logic             w_issue;
  logic             w_last_issue;
  logic             w_cap;
  logic [IDX_W-1:0] w_cap_idx;
  logic             w_last_cap;
  state_t           w_assy_nxt;

  // Capture side: the oldest pipe stage says whether sbox_data is ours.
  assign w_cap      = r_pipe_vld[SBOX_LATENCY-1];
  assign w_cap_idx  = r_pipe_idx[SBOX_LATENCY-1];
  assign w_last_cap = w_cap && (w_cap_idx == LAST_IDX);
  assign w_assy_nxt = put_byte(r_assy, int'(w_cap_idx), sbox_data);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SUB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and control decodes.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_last_issue = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      SUB_IDLE, SUB_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SUB_ISSUE;
        end
      end
      SUB_ISSUE: begin
        busy    = 1'b1;
        w_issue = 1'b1;
        if (r_issue_cnt == LAST_CNT) begin
          w_last_issue = 1'b1;
          w_state_nxt  = SUB_DRAIN;
        end
      end
      SUB_DRAIN: begin
        busy = 1'b1;
        if (w_last_cap) begin
          w_state_nxt = SUB_DONE;
        end
      end
      default: begin
        w_state_nxt = SUB_IDLE;
      end
    endcase
  end

  // Input capture and byte issue towards the S-Box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_sbox_addr <= '0;
      r_issue_cnt <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_idx   <= '0;
    end else if (w_accept) begin
      // Byte 0 is issued straight from state_in on the accepting edge.
      r_data      <= state_in;
      r_sbox_addr <= get_byte(state_in, 0);
      r_issue_cnt <= CNT_W'(1);
      r_iss_vld   <= 1'b1;
      r_iss_idx   <= '0;
    end else if (w_issue) begin
      r_sbox_addr <= get_byte(r_data, int'(r_issue_cnt));
      r_issue_cnt <= w_last_issue ? '0 : r_issue_cnt + CNT_W'(1);
      r_iss_vld   <= 1'b1;
      r_iss_idx   <= r_issue_cnt[IDX_W-1:0];
    end else begin
      // sbox_addr holds its last value; nothing new is tagged.
      r_iss_vld   <= 1'b0;
    end
  end

  // Tag pipe: shifts every cycle so each tag meets its S-Box output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < SBOX_LATENCY; i++) begin
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= r_iss_vld;
      r_pipe_idx[0] <= r_iss_idx;
      for (int i = 1; i < SBOX_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  // Result assembly and publication on the last captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_assy <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_cap;
      if (w_accept) begin
        r_assy <= '0;
      end else if (w_cap) begin
        r_assy <= w_assy_nxt;
      end
      if (w_last_cap) begin
        r_out <= w_assy_nxt;
      end
    end
  end

  assign done      = r_done;
  assign state_out = r_out;
  assign sbox_addr = r_sbox_addr;

endmodule
